// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter/sequencer that shares one UART transmitter
//               between NREQ byte producers. Latches one byte from the winner,
//               pulses tx_send, then follows tx_done through the whole frame
//               before granting again. A requester keeps the channel locked
//               until it sends a byte marked req_last, or until it has left
//               req low for LOCK_TIMEOUT idle cycles.
// Ports       : clock, reset        - clock, synchronous active-high reset
//               req/req_data/req_last - per-requester request, byte, end-of-burst
//               ack                 - one-cycle pulse to the accepted requester
//               grant_id, locked    - last accepted requester, channel reserved
//               busy                - a byte is in flight
//               tx_data, tx_send    - to transmitter txdata / send
//               tx_done             - from transmitter txdone (high = idle)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   ack,
  output logic [2:0]        grant_id,
  output logic              locked,
  output logic              busy,
  output logic [7:0]        tx_data,
  output logic              tx_send,
  input  logic              tx_done
);

  localparam logic [7:0] TIMEOUT_C = 8'(LOCK_TIMEOUT);
  localparam logic [3:0] NREQ_C    = 4'(NREQ);
  localparam logic [2:0] LAST_ID_C = 3'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  ptr, ptr_nxt;
  logic [7:0]  lock_cnt, lock_cnt_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic [2:0]  grant_nxt;
  logic        locked_nxt;
  logic [7:0]  data_nxt;
  logic        send_nxt;

  // Request vectors zero-padded to 8 bits so they can be indexed by any
  // 3-bit requester id regardless of NREQ.
  logic [7:0]  req_pad;
  logic [7:0]  last_pad;
  logic [3:0]  cand;
  logic        win_found;
  logic [2:0]  win_id;
  logic [7:0]  win_data;
  logic [7:0]  win_onehot;

  always_comb begin
    req_pad  = '0;
    last_pad = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_pad[i]  = req[i];
      last_pad[i] = req_last[i];
    end
  end

  // Winner selection. While locked only the owner is eligible; otherwise the
  // search starts at the pointer and wraps, first set bit wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    if (locked) begin
      win_found = req_pad[grant_id];
      win_id    = grant_id;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        cand = {1'b0, ptr} + 4'(i);
        if (cand >= NREQ_C) begin
          cand = cand - NREQ_C;
        end
        if (!win_found && req_pad[cand[2:0]]) begin
          win_found = 1'b1;
          win_id    = cand[2:0];
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == 3'(i)) begin
        win_data = req_data[8*i +: 8];
      end
    end
  end

  assign win_onehot = 8'd1 << win_id;

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    lock_cnt_nxt = lock_cnt;
    ack_nxt      = '0;
    send_nxt     = 1'b0;
    grant_nxt    = grant_id;
    locked_nxt   = locked;
    data_nxt     = tx_data;
    case (state)
      IDLE: begin
        if (tx_done && win_found) begin
          data_nxt     = win_data;
          ack_nxt      = win_onehot[NREQ-1:0];
          send_nxt     = 1'b1;
          grant_nxt    = win_id;
          locked_nxt   = ~last_pad[win_id];
          lock_cnt_nxt = '0;
          ptr_nxt      = (win_id == LAST_ID_C) ? 3'd0 : win_id + 3'd1;
          state_nxt    = WAIT_BUSY;
        end else if (locked && !req_pad[grant_id]) begin
          // Owner went quiet: drop the lock once it has idled long enough.
          if (lock_cnt == TIMEOUT_C - 8'd1) begin
            locked_nxt   = 1'b0;
            lock_cnt_nxt = '0;
          end else begin
            lock_cnt_nxt = lock_cnt + 8'd1;
          end
        end
      end
      WAIT_BUSY: begin
        // The transmitter needs a cycle to see send before txdone falls.
        if (!tx_done) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      lock_cnt <= '0;
      ack      <= '0;
      tx_send  <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      lock_cnt <= lock_cnt_nxt;
      ack      <= ack_nxt;
      tx_send  <= send_nxt;
      tx_data  <= data_nxt;
      grant_id <= grant_nxt;
      locked   <= locked_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with a small
//               transmitter model (txdone low for FRAME cycles after send).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int FRAME = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  ack;
  logic [2:0]  grant_id;
  logic        locked;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_done;

  int checks = 0;
  int errors = 0;

  logic tx_busy;
  logic tx_stall;
  int   tx_cnt;

  uart_tx_arbiter #(
    .NREQ        (NREQ),
    .LOCK_TIMEOUT(4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .req_data(req_data),
    .req_last(req_last),
    .ack     (ack),
    .grant_id(grant_id),
    .locked  (locked),
    .busy    (busy),
    .tx_data (tx_data),
    .tx_send (tx_send),
    .tx_done (tx_done)
  );

  always #5 clock = ~clock;

  // Transmitter model: send seen while idle starts a FRAME-cycle frame.
  always @(posedge clock) begin
    if (reset) begin
      tx_busy <= 1'b0;
      tx_cnt  <= 0;
    end else if (!tx_busy && tx_send) begin
      tx_busy <= 1'b1;
      tx_cnt  <= FRAME;
    end else if (tx_busy) begin
      if (tx_cnt == 1) tx_busy <= 1'b0;
      tx_cnt <= tx_cnt - 1;
    end
  end

  assign tx_done = ~tx_busy & ~tx_stall;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    tick();
    while (ack == 4'b0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack"},     32'(ack),      32'h0);
    chk({tag, "_send"},    32'(tx_send),  32'h0);
    chk({tag, "_data"},    32'(tx_data),  32'h0);
    chk({tag, "_grant"},   32'(grant_id), 32'h0);
    chk({tag, "_locked"},  32'(locked),   32'h0);
    chk({tag, "_busy"},    32'(busy),     32'h0);
  endtask

  task automatic do_reset();
    req   = 4'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    req      = 4'b0;
    req_data = 32'h0;
    req_last = 4'b0;
    tx_stall = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;

    // ---- Single byte ----
    req_data[7:0] = 8'h5A;
    req_last      = 4'b0001;
    req           = 4'b0001;
    wait_ack();
    chk("single_ack",    32'(ack),      32'h1);
    chk("single_send",   32'(tx_send),  32'h1);
    chk("single_data",   32'(tx_data),  32'h5A);
    chk("single_locked", 32'(locked),   32'h0);
    chk("single_busy",   32'(busy),     32'h1);
    req = 4'b0;
    tick();
    chk("single_ack_off",  32'(ack),     32'h0);
    chk("single_send_off", 32'(tx_send), 32'h0);
    for (int n = 0; n < 40 && !tx_done; n++) begin
      chk("single_hold", 32'(tx_data), 32'h5A);
      tick();
    end
    chk("single_busy_done", 32'(busy), 32'h1);
    tick();
    chk("single_idle", 32'(busy), 32'h0);

    // ---- Round robin ----
    do_reset();
    req_data = 32'h13121110;
    req_last = 4'b1111;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack();
      chk("rr_ack",   32'(ack),      32'(1 << (k % 4)));
      chk("rr_grant", 32'(grant_id), 32'(k % 4));
      chk("rr_data",  32'(tx_data),  32'(8'h10 + (k % 4)));
    end
    req = 4'b0;
    wait_idle();
    chk("rr_idle", 32'(busy), 32'h0);

    // ---- Burst lock ----
    do_reset();
    req_data       = 32'h0;
    req_data[7:0]  = 8'hB0;
    req_data[23:16] = 8'hA1;
    req_last       = 4'b0001;
    req            = 4'b0100;
    wait_ack();
    chk("burst1_ack",    32'(ack),     32'h4);
    chk("burst1_data",   32'(tx_data), 32'hA1);
    chk("burst1_locked", 32'(locked),  32'h1);
    req             = 4'b0101;
    req_data[23:16] = 8'hA2;
    wait_ack();
    chk("burst2_ack",    32'(ack),     32'h4);
    chk("burst2_data",   32'(tx_data), 32'hA2);
    chk("burst2_locked", 32'(locked),  32'h1);
    req_data[23:16] = 8'hA3;
    req_last        = 4'b0101;
    wait_ack();
    chk("burst3_ack",    32'(ack),     32'h4);
    chk("burst3_data",   32'(tx_data), 32'hA3);
    chk("burst3_locked", 32'(locked),  32'h0);
    req = 4'b0001;
    wait_ack();
    chk("burst_r0_ack",   32'(ack),      32'h1);
    chk("burst_r0_data",  32'(tx_data),  32'hB0);
    chk("burst_r0_grant", 32'(grant_id), 32'h0);
    req = 4'b0;
    wait_idle();

    // ---- Lock timeout (LOCK_TIMEOUT = 4) ----
    do_reset();
    req_data        = 32'h0;
    req_data[15:8]  = 8'hC1;
    req_data[31:24] = 8'hD3;
    req_last        = 4'b1000;
    req             = 4'b0010;
    wait_ack();
    chk("to_ack1",    32'(ack),    32'h2);
    chk("to_locked1", 32'(locked), 32'h1);
    req = 4'b1000;
    wait_idle();
    chk("to_idle", 32'(busy), 32'h0);
    for (int n = 1; n <= 3; n++) begin
      tick();
      chk("to_still_locked", 32'(locked), 32'h1);
      chk("to_no_ack",       32'(ack),    32'h0);
    end
    tick();
    chk("to_unlocked",   32'(locked), 32'h0);
    chk("to_no_ack4",    32'(ack),    32'h0);
    tick();
    chk("to_r3_ack",   32'(ack),      32'h8);
    chk("to_r3_grant", 32'(grant_id), 32'h3);
    chk("to_r3_data",  32'(tx_data),  32'hD3);
    req = 4'b0;
    wait_idle();

    // ---- Stall and reset ----
    do_reset();
    tx_stall        = 1'b1;
    req_data        = 32'h0;
    req_data[23:16] = 8'h77;
    req_last        = 4'b0101;
    req             = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("stall_no_ack", 32'(ack),  32'h0);
      chk("stall_idle",   32'(busy), 32'h0);
    end
    tx_stall = 1'b0;
    wait_ack();
    chk("stall_ack",   32'(ack),      32'h4);
    chk("stall_data",  32'(tx_data),  32'h77);
    chk("stall_grant", 32'(grant_id), 32'h2);
    req = 4'b0;
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    check_reset_vals("midreset");
    req_data[7:0] = 8'h99;
    req           = 4'b0001;
    reset         = 1'b0;
    tick();
    chk("post_ack",  32'(ack),     32'h1);
    chk("post_send", 32'(tx_send), 32'h1);
    chk("post_data", 32'(tx_data), 32'h99);
    req = 4'b0;
    wait_idle();
    chk("post_idle", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
